// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_seq_state_e;

   localparam int unsigned LOSS_W = 8;

   // Largest of three cycle parameters; sizes the shared cycle counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two back-to-back stages to resolve metastability of the async input.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives PLL reset, qualifies lock, releases the
// system reset, retries on timeout and latches FAIL after MAX_RETRY failures.
// Optional feature macro: LOSS_COUNTER_EN (lock-loss event counter).
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 65536,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_locked,
   input  logic                             i_retry,
   output logic                             o_pll_reset,
   output logic                             o_sys_rst_n,
   output logic                             o_ready,
   output logic                             o_fail,
   output logic [$clog2(MAX_RETRY+1)-1:0]   o_attempt,
   output logic [LOSS_W-1:0]                o_loss_count
);

   localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   // One extra count of headroom: STABLE compares against STABLE_CYCLES itself.
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned ATT_W   = $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES);
   localparam logic [ATT_W-1:0] ATT_LIMIT    = ATT_W'(MAX_RETRY);

   pll_seq_state_e   state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ATT_W-1:0] attempt_q, attempt_d;
   logic [ATT_W-1:0] attempt_inc;
   logic             pll_reset_q, pll_reset_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;
   logic             fail_attempt;
   logic             locked_s;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_locked),
      .o_q     (locked_s)
   );

   assign attempt_inc = attempt_q + ATT_W'(1);

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= PLL_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision; lock is checked before timeout so lock wins a tie.
   always_comb begin
      state_d      = state_q;
      fail_attempt = 1'b0;
      unique case (state_q)
         PLL_RST: begin
            if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s)                   state_d      = STABLE;
            else if (cnt_q == TIMEOUT_LAST) fail_attempt = 1'b1;
         end
         STABLE: begin
            if (!locked_s)                 fail_attempt = 1'b1;
            else if (cnt_q == STABLE_LAST) state_d      = RUN;
         end
         RUN: begin
            if (!locked_s) state_d = PLL_RST;
         end
         FAIL: begin
            if (i_retry) state_d = PLL_RST;
         end
         default: state_d = PLL_RST;
      endcase
      if (fail_attempt) begin
         state_d = (attempt_inc == ATT_LIMIT) ? FAIL : PLL_RST;
      end
   end

   // Output and counter next values; outputs follow the state being entered.
   always_comb begin
      pll_reset_d = (state_d == PLL_RST) || (state_d == FAIL);
      sys_rst_n_d = (state_d == RUN);
      ready_d     = (state_d == RUN);
      fail_d      = (state_d == FAIL);

      if (state_d != state_q)                        cnt_d = '0;
      else if ((state_q == RUN) || (state_q == FAIL)) cnt_d = cnt_q;
      else                                           cnt_d = cnt_q + CNT_W'(1);

      attempt_d = attempt_q;
      if (fail_attempt)                                attempt_d = attempt_inc;
      else if (state_d == RUN)                         attempt_d = '0;
      else if ((state_q == FAIL) && (state_d == PLL_RST)) attempt_d = '0;
   end

   // Registered outputs and sequencing counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         attempt_q   <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         attempt_q   <= attempt_d;
         pll_reset_q <= pll_reset_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

`ifdef LOSS_COUNTER_EN
   logic [LOSS_W-1:0] loss_q, loss_d;

   // Count lock-loss exits from RUN, saturating at all-ones.
   always_comb begin
      loss_d = loss_q;
      if ((state_q == RUN) && (state_d == PLL_RST) && (loss_q != '1)) begin
         loss_d = loss_q + LOSS_W'(1);
      end
   end

   // Loss counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         loss_q <= '0;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign o_loss_count = loss_q;
`else
   assign o_loss_count = '0;
`endif

   assign o_pll_reset = pll_reset_q;
   assign o_sys_rst_n = sys_rst_n_q;
   assign o_ready     = ready_q;
   assign o_fail      = fail_q;
   assign o_attempt   = attempt_q;

endmodule
